// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates the branch condition, predicts from a 2-bit
// pattern history table, and reports outcome, misprediction and statistics.
module branch_resolve_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PHT_DEPTH = 64,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InValid,
    input  logic [WIDTH-1:0]     InA,
    input  logic [WIDTH-1:0]     InB,
    input  logic [2:0]           Control,
    input  logic [PC_WIDTH-1:0]  PC,
    input  logic                 Flush,
    output logic                 Predicted,
    output logic                 OutValid,
    output logic                 Taken,
    output logic                 Mispredict,
    output logic                 Link,
    output logic [CNT_WIDTH-1:0] BranchCount,
    output logic [CNT_WIDTH-1:0] MissCount
);

    localparam int unsigned IDX_W = $clog2(PHT_DEPTH);

    localparam logic [2:0] OP_BEQ    = 3'b000;
    localparam logic [2:0] OP_BGEZ   = 3'b001;
    localparam logic [2:0] OP_BGTZ   = 3'b010;
    localparam logic [2:0] OP_BLEZ   = 3'b011;
    localparam logic [2:0] OP_BLTZ   = 3'b100;
    localparam logic [2:0] OP_BNE    = 3'b101;
    localparam logic [2:0] OP_BGEZAL = 3'b110;
    localparam logic [2:0] OP_BLTZAL = 3'b111;

    typedef logic [1:0] ctr_t;

    ctr_t                 pht_q [PHT_DEPTH];
    ctr_t                 pht_d [PHT_DEPTH];
    logic                 out_valid_q, out_valid_d;
    logic                 taken_q, taken_d;
    logic                 mispredict_q, mispredict_d;
    logic                 link_q, link_d;
    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

    logic [IDX_W-1:0]     idx;
    logic                 accept;
    logic                 a_neg;
    logic                 a_zero;
    logic                 cond;
    logic                 unused_pc;

    assign idx       = PC[IDX_W+1:2];
    assign unused_pc = ^{PC[PC_WIDTH-1:IDX_W+2], PC[1:0]};
    assign accept    = InValid && !Flush;
    assign a_neg     = InA[WIDTH-1];
    assign a_zero    = (InA == '0);
    assign Predicted = pht_q[idx][1];

    // Branch condition; zero compares use InA as a signed value
    always_comb begin
        cond = 1'b0;
        case (Control)
            OP_BEQ:    cond = (InA == InB);
            OP_BGEZ:   cond = !a_neg;
            OP_BGTZ:   cond = !a_neg && !a_zero;
            OP_BLEZ:   cond = a_neg || a_zero;
            OP_BLTZ:   cond = a_neg;
            OP_BNE:    cond = (InA != InB);
            OP_BGEZAL: cond = !a_neg;
            OP_BLTZAL: cond = a_neg;
            default:   cond = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d    = 1'b0;
        taken_d        = 1'b0;
        mispredict_d   = 1'b0;
        link_d         = 1'b0;
        branch_count_d = branch_count_q;
        miss_count_d   = miss_count_q;
        pht_d          = pht_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            taken_d      = cond;
            mispredict_d = cond ^ Predicted;
            link_d       = (Control == OP_BGEZAL) || (Control == OP_BLTZAL);
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + CNT_WIDTH'(1);
            end
            if (mispredict_d && (miss_count_q != '1)) begin
                miss_count_d = miss_count_q + CNT_WIDTH'(1);
            end
            // Saturating 2-bit counter training
            if (cond && (pht_q[idx] != 2'b11)) begin
                pht_d[idx] = pht_q[idx] + 2'(1);
            end else if (!cond && (pht_q[idx] != 2'b00)) begin
                pht_d[idx] = pht_q[idx] - 2'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_valid_q    <= 1'b0;
            taken_q        <= 1'b0;
            mispredict_q   <= 1'b0;
            link_q         <= 1'b0;
            branch_count_q <= '0;
            miss_count_q   <= '0;
            pht_q          <= '{default: 2'b01};
        end else begin
            out_valid_q    <= out_valid_d;
            taken_q        <= taken_d;
            mispredict_q   <= mispredict_d;
            link_q         <= link_d;
            branch_count_q <= branch_count_d;
            miss_count_q   <= miss_count_d;
            pht_q          <= pht_d;
        end
    end

    assign OutValid    = out_valid_q;
    assign Taken       = taken_q;
    assign Mispredict  = mispredict_q;
    assign Link        = link_q;
    assign BranchCount = branch_count_q;
    assign MissCount   = miss_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit against a behavioural model
// of branch conditions, 2-bit predictor training and saturating statistics.
module tb_branch_resolve_unit;

    localparam int unsigned CW     = 8;
    localparam int          CNTMAX = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  ctl;
    logic [31:0] pc;
    logic        flush;
    logic        predicted;
    logic        out_valid;
    logic        taken;
    logic        mispredict;
    logic        link;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] miss_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pht [64];
    int m_bc;
    int m_mc;
    bit exp_pred, exp_ov, exp_t, exp_m, exp_l;
    logic obs_pred;

    branch_resolve_unit #(
        .WIDTH(32), .PHT_DEPTH(64), .PC_WIDTH(32), .CNT_WIDTH(CW)
    ) dut (
        .Clock(clk), .Reset(rst), .InValid(in_valid), .InA(in_a), .InB(in_b),
        .Control(ctl), .PC(pc), .Flush(flush), .Predicted(predicted),
        .OutValid(out_valid), .Taken(taken), .Mispredict(mispredict),
        .Link(link), .BranchCount(branch_count), .MissCount(miss_count)
    );

    always #5 clk = ~clk;

    function automatic bit ref_cond(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] c);
        longint sa;
        sa = longint'($signed(a));
        case (c)
            3'd0: return a == b;
            3'd1: return sa >= 0;
            3'd2: return sa > 0;
            3'd3: return sa <= 0;
            3'd4: return sa < 0;
            3'd5: return a != b;
            3'd6: return sa >= 0;
            default: return sa < 0;
        endcase
    endfunction

    // Drives one cycle, samples Predicted before the edge, advances the model
    task automatic apply(input bit r, input bit v, input bit f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [31:0] p);
        int ix;
        bit t;
        @(negedge clk);
        rst = r; in_valid = v; flush = f; in_a = a; in_b = b; ctl = c; pc = p;
        #1;
        ix = int'(p[7:2]);
        exp_pred = (m_pht[ix] >= 2);
        obs_pred = predicted;
        @(posedge clk);
        #1;
        exp_ov = 0; exp_t = 0; exp_m = 0; exp_l = 0;
        if (r) begin
            for (int i = 0; i < 64; i++) m_pht[i] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (v && !f) begin
            t = ref_cond(a, b, c);
            exp_ov = 1;
            exp_t = t;
            exp_m = (t != exp_pred);
            exp_l = (c >= 3'd6);
            m_bc = (m_bc + 1 > CNTMAX) ? CNTMAX : m_bc + 1;
            if (exp_m) m_mc = (m_mc + 1 > CNTMAX) ? CNTMAX : m_mc + 1;
            m_pht[ix] = t ? ((m_pht[ix] + 1 > 3) ? 3 : m_pht[ix] + 1)
                          : ((m_pht[ix] - 1 < 0) ? 0 : m_pht[ix] - 1);
        end
    endtask

    task automatic test_reset;
        apply(1, 1, 0, 32'd5, 32'd5, 3'd0, 32'h40);
        apply(1, 0, 0, 0, 0, 3'd0, 0);
        checks++; if (out_valid !== 1'b0 || taken !== 1'b0 || mispredict !== 1'b0 || link !== 1'b0) begin
            errors++; $display("FAIL reset_outs: got ov=%b t=%b m=%b l=%b required 0000", out_valid, taken, mispredict, link);
        end
        checks++; if (branch_count !== '0 || miss_count !== '0) begin
            errors++; $display("FAIL reset_counts: got bc=%0d mc=%0d required 0 0", branch_count, miss_count);
        end
        apply(0, 0, 0, 0, 0, 3'd0, 0);
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dropped_input: got ov=%b required 0", out_valid);
        end
        @(negedge clk);
        rst = 0; in_valid = 0;
        for (int i = 0; i < 64; i++) begin
            pc = 32'(i * 4) | 32'h1000;
            #1;
            checks++; if (predicted !== 1'b0) begin
                errors++; $display("FAIL reset_predicted[%0d]: got %b required 0", i, predicted);
            end
        end
    endtask

    task automatic test_beq_stream;
        bit req_m [3] = '{1'b1, 1'b0, 1'b0};
        int req_p [3] = '{2, 3, 3};
        apply(1, 0, 0, 0, 0, 3'd0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 32'd5, 32'd5, 3'd0, 32'h40);
            checks++; if (out_valid !== 1'b1 || taken !== 1'b1 || mispredict !== req_m[i]) begin
                errors++; $display("FAIL beq_stream[%0d]: got ov=%b t=%b m=%b required 1 1 %b", i, out_valid, taken, mispredict, req_m[i]);
            end
            checks++; if (dut.pht_q[16] !== 2'(req_p[i])) begin
                errors++; $display("FAIL beq_pht[%0d]: got %0d required %0d", i, dut.pht_q[16], req_p[i]);
            end
        end
        checks++; if (branch_count !== CW'(3) || miss_count !== CW'(1)) begin
            errors++; $display("FAIL beq_counts: got bc=%0d mc=%0d required 3 1", branch_count, miss_count);
        end
    endtask

    task automatic test_signed;
        logic [31:0] av [5] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'd3};
        logic [2:0]  cv [5] = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd5};
        bit          tv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, av[i], 32'd3, cv[i], 32'h100 + 32'(i * 4));
            checks++; if (taken !== tv[i] || out_valid !== 1'b1) begin
                errors++; $display("FAIL signed[%0d]: got t=%b ov=%b required %b 1", i, taken, out_valid, tv[i]);
            end
        end
    endtask

    task automatic test_link;
        apply(0, 1, 0, 32'd1, 32'hDEAD, 3'd7, 32'h200);
        checks++; if (taken !== 1'b0 || link !== 1'b1) begin
            errors++; $display("FAIL bltzal: got t=%b l=%b required 0 1", taken, link);
        end
        apply(0, 1, 0, 32'd1, 32'hBEEF, 3'd6, 32'h204);
        checks++; if (taken !== 1'b1 || link !== 1'b1) begin
            errors++; $display("FAIL bgezal: got t=%b l=%b required 1 1", taken, link);
        end
    endtask

    task automatic test_flush;
        int bc0;
        int p0;
        bc0 = m_bc;
        p0 = m_pht[32];
        apply(0, 1, 1, 32'd9, 32'd9, 3'd0, 32'h80);
        checks++; if (out_valid !== 1'b0 || taken !== 1'b0) begin
            errors++; $display("FAIL flush_out: got ov=%b t=%b required 0 0", out_valid, taken);
        end
        checks++; if (dut.pht_q[32] !== 2'(p0) || branch_count !== CW'(bc0)) begin
            errors++; $display("FAIL flush_state: got pht=%0d bc=%0d required %0d %0d", dut.pht_q[32], branch_count, p0, bc0);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, p;
        logic [2:0] c;
        bit v, f;
        for (int i = 0; i < 300; i++) begin
            a = $urandom();
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 2)) - 32'd1;
            b = ($urandom_range(0, 1) == 1) ? a : $urandom();
            c = 3'($urandom_range(0, 7));
            p = {$urandom(), 2'b00} & 32'hFFFF_001C;
            v = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 9) == 0);
            apply(0, v, f, a, b, c, p);
            checks++; if (obs_pred !== exp_pred) begin
                errors++; $display("FAIL rand_pred[%0d]: got %b required %b", i, obs_pred, exp_pred);
            end
            checks++; if (out_valid !== exp_ov || taken !== exp_t || mispredict !== exp_m || link !== exp_l) begin
                errors++; $display("FAIL rand_out[%0d]: got %b%b%b%b required %b%b%b%b", i,
                    out_valid, taken, mispredict, link, exp_ov, exp_t, exp_m, exp_l);
            end
            checks++; if (branch_count !== CW'(m_bc) || miss_count !== CW'(m_mc)) begin
                errors++; $display("FAIL rand_cnt[%0d]: got bc=%0d mc=%0d required %0d %0d", i, branch_count, miss_count, m_bc, m_mc);
            end
        end
    endtask

    task automatic test_saturation;
        apply(1, 0, 0, 0, 0, 3'd0, 0);
        for (int i = 0; i < CNTMAX - 1; i++) begin
            apply(0, 1, 0, 32'($urandom_range(0, 1)), 32'd0, 3'd0, {$urandom(), 2'b00} & 32'hFC);
        end
        checks++; if (branch_count !== CW'(CNTMAX - 1)) begin
            errors++; $display("FAIL sat_pre: got %0d required %0d", branch_count, CNTMAX - 1);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 32'd1, 32'd1, 3'd0, 32'h44);
            checks++; if (branch_count !== CW'(CNTMAX) || miss_count !== CW'(m_mc)) begin
                errors++; $display("FAIL sat_hold[%0d]: got bc=%0d mc=%0d required %0d %0d", i, branch_count, miss_count, CNTMAX, m_mc);
            end
        end
    endtask

    task automatic test_reset_mid_stream;
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 32'd7, 32'd7, 3'd0, 32'h40);
        apply(1, 1, 0, 32'd7, 32'd7, 3'd0, 32'h40);
        checks++; if (out_valid !== 1'b0 || taken !== 1'b0 || mispredict !== 1'b0 || link !== 1'b0 || branch_count !== '0 || miss_count !== '0) begin
            errors++; $display("FAIL midreset_outs: got %b%b%b%b bc=%0d mc=%0d required all 0", out_valid, taken, mispredict, link, branch_count, miss_count);
        end
        @(negedge clk);
        rst = 0; in_valid = 0; pc = 32'h40;
        #1;
        checks++; if (predicted !== 1'b0) begin
            errors++; $display("FAIL midreset_pred: got %b required 0", predicted);
        end
        apply(0, 1, 0, 32'd7, 32'd7, 3'd0, 32'h40);
        checks++; if (taken !== 1'b1 || mispredict !== 1'b1 || dut.pht_q[16] !== 2'b10) begin
            errors++; $display("FAIL midreset_first: got t=%b m=%b pht=%0d required 1 1 2", taken, mispredict, dut.pht_q[16]);
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; flush = 0; in_a = 0; in_b = 0; ctl = 0; pc = 0;
        test_reset();
        test_beq_stream();
        test_signed();
        test_link();
        test_flush();
        test_random();
        test_saturation();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
